fall_ctrl: RTL and testbench

Gravity controller directly downstream of game_clock. Converts the game_clk level into single-cycle ticks and decides when the active tetromino must try to move down one row, using a level-dependent interval. Issues a req/ack probe to the board/collision logic and runs lock-delay timing. Pulses lock_piece when the piece must be frozen into the board.

---
 rtl/fall_pkg.sv | 26 ++
 rtl/tick_edge.sv | 35 +++
 rtl/fall_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_fall_ctrl.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fall_pkg.sv
// ----------------------------------------------------------------------------
// fall_pkg
// Shared definitions for the gravity controller:
//   - fall_state_t : controller state encoding (3-bit)
//   - DEF_*        : default timing constants used as parameter defaults
// ----------------------------------------------------------------------------
package fall_pkg;

  // Gravity controller states. Encoding is fixed so debug taps and any
  // downstream logic decoding the state see stable values.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FALL    = 3'd1,
    REQ     = 3'd2,
    LOCK    = 3'd3,
    LOCKOUT = 3'd4
  } fall_state_t;

  // Ticks per row at level 0.
  localparam int DEF_MAX_INTERVAL = 12;
  // Floor on ticks per row at high levels.
  localparam int DEF_MIN_INTERVAL = 1;
  // Ticks a blocked piece waits before it is frozen.
  localparam int DEF_LOCK_TICKS   = 3;

endpackage : fall_pkg

// File: rtl/tick_edge.sv
// ----------------------------------------------------------------------------
// tick_edge
// Rising-edge detector for a level signal in the clk domain, with a gate
// that suppresses the tick. The history register keeps sampling while
// gated, so an edge that happens while gated is dropped rather than
// delivered later.
//
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-low reset
//   sig   in  level signal to watch (already synchronous to clk)
//   pause in  suppresses the tick output when high
//   tick  out one-cycle pulse on a 0->1 transition of sig while not paused
// ----------------------------------------------------------------------------
module tick_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  input  logic pause,
  output logic tick
);

  logic sig_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_reg <= 1'b0;
    end else begin
      sig_reg <= sig;
    end
  end

  assign tick = sig & ~sig_reg & ~pause;

endmodule : tick_edge

// File: rtl/fall_ctrl.sv
// ----------------------------------------------------------------------------
// fall_ctrl
// Gravity controller. Turns game_clk edges into ticks, counts ticks against
// a level-dependent interval, probes the board with a fall_req/fall_ack
// handshake, and runs lock-delay timing once the piece is blocked. Emits a
// one-cycle lock_piece when the piece must be frozen.
//
// Ports:
//   clk         in  system clock
//   rst         in  asynchronous active-low reset
//   game_clk    in  divided game clock level (same clk domain)
//   pause       in  freezes gravity and lock timing
//   level       in  current game level
//   soft_drop   in  forces one tick per row
//   spawn       in  one-cycle pulse: new piece placed
//   fall_req    out request board to move the piece down one row
//   fall_ack    in  board response strobe (only honoured in REQ)
//   fall_ok     in  with fall_ack: 1 = moved down, 0 = blocked
//   piece_moved in  one-cycle pulse: lateral move / rotation succeeded
//   lock_piece  out one-cycle pulse: freeze piece into board
//   active      out a piece is under gravity control
//   tick_cnt    out current fall counter (debug)
// ----------------------------------------------------------------------------
module fall_ctrl
  import fall_pkg::*;
#(
  parameter int CNT_W        = 4,
  parameter int LEVEL_W      = 4,
  parameter int MAX_INTERVAL = DEF_MAX_INTERVAL,
  parameter int MIN_INTERVAL = DEF_MIN_INTERVAL,
  parameter int LOCK_TICKS   = DEF_LOCK_TICKS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_clk,
  input  logic               pause,
  input  logic [LEVEL_W-1:0] level,
  input  logic               soft_drop,
  input  logic               spawn,
  output logic               fall_req,
  input  logic               fall_ack,
  input  logic               fall_ok,
  input  logic               piece_moved,
  output logic               lock_piece,
  output logic               active,
  output logic [CNT_W-1:0]   tick_cnt
);

  // Constants widened to the counter arithmetic width (one guard bit).
  localparam logic [CNT_W:0]   MAX_EXT  = (CNT_W+1)'(MAX_INTERVAL);
  localparam logic [CNT_W:0]   MIN_EXT  = (CNT_W+1)'(MIN_INTERVAL);
  localparam logic [CNT_W:0]   LOCK_EXT = (CNT_W+1)'(LOCK_TICKS);
  localparam logic [CNT_W:0]   ONE_EXT  = (CNT_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  fall_state_t       state_reg;
  logic [CNT_W-1:0]  fall_cnt_reg;
  logic [CNT_W-1:0]  lock_cnt_reg;

  logic              tick;
  logic [CNT_W:0]    level_ext;
  logic [CNT_W:0]    interval_diff;
  logic [CNT_W-1:0]  interval;
  logic              fall_hit;
  logic              lock_hit;

  // --------------------------------------------------------------------------
  // game_clk edge -> tick (gated by pause)
  // --------------------------------------------------------------------------
  tick_edge u_tick_edge (
    .clk   (clk),
    .rst   (rst),
    .sig   (game_clk),
    .pause (pause),
    .tick  (tick)
  );

  // --------------------------------------------------------------------------
  // Interval: MAX_INTERVAL - level, floored at MIN_INTERVAL. The subtraction
  // carries a guard bit so a level above MAX_INTERVAL shows up as a set MSB
  // (negative result) and saturates to the floor instead of wrapping.
  // --------------------------------------------------------------------------
  always_comb begin
    level_ext     = (CNT_W+1)'(level);
    interval_diff = MAX_EXT - level_ext;
    if (soft_drop) begin
      interval = CNT_ONE;
    end else if (interval_diff[CNT_W] || (interval_diff < MIN_EXT)) begin
      interval = MIN_EXT[CNT_W-1:0];
    end else begin
      interval = interval_diff[CNT_W-1:0];
    end
  end

  // ">=" rather than "==" so that a level change which shrinks the interval
  // below the current count still requests on the very next tick.
  assign fall_hit = (({1'b0, fall_cnt_reg} + ONE_EXT) >= {1'b0, interval});
  assign lock_hit = (({1'b0, lock_cnt_reg} + ONE_EXT) == LOCK_EXT);

  // --------------------------------------------------------------------------
  // Controller FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      fall_cnt_reg <= '0;
      lock_cnt_reg <= '0;
      fall_req     <= 1'b0;
      lock_piece   <= 1'b0;
      active       <= 1'b0;
    end else begin
      // lock_piece is only ever set on entry to LOCKOUT, which always leaves
      // after one cycle, so it can never be high two cycles in a row.
      lock_piece <= 1'b0;

      if (spawn) begin
        // A new piece overrides everything, including an outstanding probe;
        // any late ack is then ignored because we are no longer in REQ.
        state_reg    <= FALL;
        fall_cnt_reg <= '0;
        lock_cnt_reg <= '0;
        fall_req     <= 1'b0;
        active       <= 1'b1;
      end else begin
        unique case (state_reg)
          IDLE: begin
            fall_req <= 1'b0;
            active   <= 1'b0;
          end

          FALL: begin
            if (tick) begin
              if (fall_hit) begin
                fall_cnt_reg <= '0;
                state_reg    <= REQ;
                fall_req     <= 1'b1;
              end else begin
                fall_cnt_reg <= fall_cnt_reg + CNT_ONE;
              end
            end
          end

          // The handshake is not gated by pause: the board already owns the
          // request and must be allowed to answer it.
          REQ: begin
            if (fall_ack) begin
              fall_req <= 1'b0;
              if (fall_ok) begin
                state_reg    <= FALL;
                fall_cnt_reg <= '0;
              end else begin
                state_reg    <= LOCK;
                lock_cnt_reg <= '0;
              end
            end
          end

          // A successful move/rotation re-probes the board and restarts the
          // lock delay; it takes priority over a tick in the same cycle.
          LOCK: begin
            if (piece_moved && !pause) begin
              state_reg    <= REQ;
              fall_req     <= 1'b1;
              lock_cnt_reg <= '0;
            end else if (tick) begin
              if (lock_hit) begin
                state_reg    <= LOCKOUT;
                lock_piece   <= 1'b1;
                lock_cnt_reg <= '0;
              end else begin
                lock_cnt_reg <= lock_cnt_reg + CNT_ONE;
              end
            end
          end

          LOCKOUT: begin
            state_reg <= IDLE;
            active    <= 1'b0;
          end

          default: begin
            state_reg    <= IDLE;
            fall_cnt_reg <= '0;
            lock_cnt_reg <= '0;
            fall_req     <= 1'b0;
            active       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tick_cnt = fall_cnt_reg;

endmodule : fall_ctrl

// File: tb/tb_fall_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fall_ctrl
// Directed testbench for fall_ctrl. Inputs change and outputs are sampled on
// the falling clock edge, half a cycle away from the active rising edge.
// ----------------------------------------------------------------------------
module tb_fall_ctrl;

  logic       clk;
  logic       rst;
  logic       game_clk;
  logic       pause;
  logic [3:0] level;
  logic       soft_drop;
  logic       spawn;
  logic       fall_req;
  logic       fall_ack;
  logic       fall_ok;
  logic       piece_moved;
  logic       lock_piece;
  logic       active;
  logic [3:0] tick_cnt;

  int checks   = 0;
  int failures = 0;

  fall_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .game_clk    (game_clk),
    .pause       (pause),
    .level       (level),
    .soft_drop   (soft_drop),
    .spawn       (spawn),
    .fall_req    (fall_req),
    .fall_ack    (fall_ack),
    .fall_ok     (fall_ok),
    .piece_moved (piece_moved),
    .lock_piece  (lock_piece),
    .active      (active),
    .tick_cnt    (tick_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_gclk();
    game_clk = 1'b1;
    step();
    game_clk = 1'b0;
    step();
  endtask

  task automatic do_spawn();
    spawn = 1'b1;
    step();
    spawn = 1'b0;
  endtask

  task automatic do_ack(input logic ok);
    fall_ack = 1'b1;
    fall_ok  = ok;
    step();
    fall_ack = 1'b0;
    fall_ok  = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    checks++;
    if (fall_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_fall_req actual=%b expected=0", fall_req);
    end
    checks++;
    if (lock_piece !== 1'b0) begin
      failures++;
      $display("FAIL reset_lock_piece actual=%b expected=0", lock_piece);
    end
    checks++;
    if (active !== 1'b0) begin
      failures++;
      $display("FAIL reset_active actual=%b expected=0", active);
    end
    checks++;
    if (tick_cnt !== 4'd0) begin
      failures++;
      $display("FAIL reset_tick_cnt actual=%0d expected=0", tick_cnt);
    end
    rst = 1'b1;
    step();
    $display("test_reset done");
  endtask

  // --------------------------------------------------------------------------
  task automatic test_level0();
    level     = 4'd0;
    soft_drop = 1'b0;
    do_spawn();
    checks++;
    if (active !== 1'b1 || tick_cnt !== 4'd0) begin
      failures++;
      $display("FAIL l0_spawn active=%b tick_cnt=%0d expected active=1 tick_cnt=0",
               active, tick_cnt);
    end
    for (int k = 1; k <= 11; k++) begin
      pulse_gclk();
      checks++;
      if (fall_req !== 1'b0 || tick_cnt !== 4'(k)) begin
        failures++;
        $display("FAIL l0_count edge=%0d fall_req=%b tick_cnt=%0d expected fall_req=0 tick_cnt=%0d",
                 k, fall_req, tick_cnt, k);
      end
    end
    game_clk = 1'b1;
    step();
    checks++;
    if (fall_req !== 1'b1 || tick_cnt !== 4'd0) begin
      failures++;
      $display("FAIL l0_req12 fall_req=%b tick_cnt=%0d expected fall_req=1 tick_cnt=0",
               fall_req, tick_cnt);
    end
    game_clk = 1'b0;
    step();
    checks++;
    if (fall_req !== 1'b1) begin
      failures++;
      $display("FAIL l0_req_hold fall_req=%b expected=1", fall_req);
    end
    do_ack(1'b1);
    checks++;
    if (fall_req !== 1'b0 || tick_cnt !== 4'd0 || active !== 1'b1) begin
      failures++;
      $display("FAIL l0_ack_ok fall_req=%b tick_cnt=%0d active=%b expected 0/0/1",
               fall_req, tick_cnt, active);
    end
    $display("test_level0 done");
  endtask

  // --------------------------------------------------------------------------
  task automatic test_fast_interval();
    logic [3:0] lv [3];
    logic       sd [3];
    lv[0] = 4'd15; sd[0] = 1'b0;
    lv[1] = 4'd11; sd[1] = 1'b0;
    lv[2] = 4'd0;  sd[2] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      level     = lv[c];
      soft_drop = sd[c];
      do_spawn();
      for (int r = 0; r < 3; r++) begin
        game_clk = 1'b1;
        step();
        checks++;
        if (fall_req !== 1'b1) begin
          failures++;
          $display("FAIL fast_req level=%0d soft=%b row=%0d fall_req=%b expected=1",
                   lv[c], sd[c], r, fall_req);
        end
        game_clk = 1'b0;
        step();
        do_ack(1'b1);
        checks++;
        if (fall_req !== 1'b0) begin
          failures++;
          $display("FAIL fast_ack level=%0d soft=%b row=%0d fall_req=%b expected=0",
                   lv[c], sd[c], r, fall_req);
        end
      end
    end
    // Level 10 -> interval 2: first tick counts, second requests.
    level     = 4'd10;
    soft_drop = 1'b0;
    do_spawn();
    pulse_gclk();
    checks++;
    if (fall_req !== 1'b0 || tick_cnt !== 4'd1) begin
      failures++;
      $display("FAIL lv10_first fall_req=%b tick_cnt=%0d expected 0/1", fall_req, tick_cnt);
    end
    game_clk = 1'b1;
    step();
    checks++;
    if (fall_req !== 1'b1) begin
      failures++;
      $display("FAIL lv10_second fall_req=%b expected=1", fall_req);
    end
    game_clk = 1'b0;
    step();
    do_ack(1'b1);
    $display("test_fast_interval done");
  endtask

  // --------------------------------------------------------------------------
  task automatic test_lock();
    level     = 4'd15;
    soft_drop = 1'b0;
    do_spawn();
    pulse_gclk();
    do_ack(1'b0);
    checks++;
    if (fall_req !== 1'b0) begin
      failures++;
      $display("FAIL lock_ack_blocked fall_req=%b expected=0", fall_req);
    end
    for (int k = 0; k < 3; k++) begin
      game_clk = 1'b1;
      step();
      checks++;
      if (lock_piece !== (k == 2) || active !== 1'b1) begin
        failures++;
        $display("FAIL lock_tick tick=%0d lock_piece=%b active=%b expected lock=%b active=1",
                 k + 1, lock_piece, active, (k == 2));
      end
      game_clk = 1'b0;
      step();
    end
    checks++;
    if (lock_piece !== 1'b0 || active !== 1'b0) begin
      failures++;
      $display("FAIL lock_after lock_piece=%b active=%b expected 0/0", lock_piece, active);
    end
    // IDLE ignores ticks.
    pulse_gclk();
    checks++;
    if (fall_req !== 1'b0 || active !== 1'b0) begin
      failures++;
      $display("FAIL idle_tick fall_req=%b active=%b expected 0/0", fall_req, active);
    end
    $display("test_lock done");
  endtask

  // --------------------------------------------------------------------------
  task automatic test_piece_moved();
    level     = 4'd15;
    soft_drop = 1'b0;
    do_spawn();
    // Outside LOCK piece_moved does nothing.
    piece_moved = 1'b1;
    step();
    piece_moved = 1'b0;
    checks++;
    if (fall_req !== 1'b0) begin
      failures++;
      $display("FAIL moved_in_fall fall_req=%b expected=0", fall_req);
    end
    pulse_gclk();
    do_ack(1'b0);
    pulse_gclk();
    pulse_gclk();
    game_clk    = 1'b1;
    piece_moved = 1'b1;
    step();
    piece_moved = 1'b0;
    checks++;
    if (fall_req !== 1'b1 || lock_piece !== 1'b0) begin
      failures++;
      $display("FAIL moved_reprobe fall_req=%b lock_piece=%b expected 1/0",
               fall_req, lock_piece);
    end
    game_clk = 1'b0;
    step();
    checks++;
    if (lock_piece !== 1'b0) begin
      failures++;
      $display("FAIL moved_no_lock lock_piece=%b expected=0", lock_piece);
    end
    do_ack(1'b0);
    for (int k = 0; k < 3; k++) begin
      game_clk = 1'b1;
      step();
      checks++;
      if (lock_piece !== (k == 2)) begin
        failures++;
        $display("FAIL moved_fresh tick=%0d lock_piece=%b expected=%b",
                 k + 1, lock_piece, (k == 2));
      end
      game_clk = 1'b0;
      step();
    end
    $display("test_piece_moved done");
  endtask

  // --------------------------------------------------------------------------
  task automatic test_pause();
    level     = 4'd0;
    soft_drop = 1'b0;
    do_spawn();
    repeat (4) pulse_gclk();
    checks++;
    if (tick_cnt !== 4'd4) begin
      failures++;
      $display("FAIL pause_pre tick_cnt=%0d expected=4", tick_cnt);
    end
    pause = 1'b1;
    repeat (5) pulse_gclk();
    checks++;
    if (tick_cnt !== 4'd4 || fall_req !== 1'b0) begin
      failures++;
      $display("FAIL pause_frozen tick_cnt=%0d fall_req=%b expected 4/0", tick_cnt, fall_req);
    end
    pause = 1'b0;
    pulse_gclk();
    checks++;
    if (tick_cnt !== 4'd5) begin
      failures++;
      $display("FAIL pause_resume tick_cnt=%0d expected=5", tick_cnt);
    end
    // Level jump leaves count 5 above interval 1: next tick requests.
    level    = 4'd15;
    game_clk = 1'b1;
    step();
    checks++;
    if (fall_req !== 1'b1) begin
      failures++;
      $display("FAIL level_jump fall_req=%b expected=1", fall_req);
    end
    game_clk = 1'b0;
    step();
    pause = 1'b1;
    do_ack(1'b1);
    checks++;
    if (fall_req !== 1'b0 || tick_cnt !== 4'd0) begin
      failures++;
      $display("FAIL pause_ack fall_req=%b tick_cnt=%0d expected 0/0", fall_req, tick_cnt);
    end
    pulse_gclk();
    checks++;
    if (fall_req !== 1'b0) begin
      failures++;
      $display("FAIL pause_no_req fall_req=%b expected=0", fall_req);
    end
    pause = 1'b0;
    $display("test_pause done");
  endtask

  // --------------------------------------------------------------------------
  task automatic test_async_reset();
    level = 4'd15;
    do_spawn();
    pulse_gclk();
    checks++;
    if (fall_req !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre fall_req=%b expected=1", fall_req);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (fall_req !== 1'b0 || active !== 1'b0 || tick_cnt !== 4'd0 || lock_piece !== 1'b0) begin
      failures++;
      $display("FAIL arst_immediate fall_req=%b active=%b tick_cnt=%0d lock_piece=%b expected all 0",
               fall_req, active, tick_cnt, lock_piece);
    end
    step();
    rst = 1'b1;
    step();
    $display("test_async_reset done");
  endtask

  // --------------------------------------------------------------------------
  task automatic test_spawn_ack();
    level = 4'd15;
    do_spawn();
    pulse_gclk();
    checks++;
    if (fall_req !== 1'b1) begin
      failures++;
      $display("FAIL sa_pre fall_req=%b expected=1", fall_req);
    end
    spawn    = 1'b1;
    fall_ack = 1'b1;
    fall_ok  = 1'b0;
    step();
    spawn    = 1'b0;
    fall_ack = 1'b0;
    checks++;
    if (fall_req !== 1'b0 || tick_cnt !== 4'd0 || active !== 1'b1) begin
      failures++;
      $display("FAIL sa_spawn_wins fall_req=%b tick_cnt=%0d active=%b expected 0/0/1",
               fall_req, tick_cnt, active);
    end
    // Late ack outside REQ is ignored.
    do_ack(1'b0);
    // Still in FALL (not LOCK): a tick at interval 1 requests.
    game_clk = 1'b1;
    step();
    checks++;
    if (fall_req !== 1'b1) begin
      failures++;
      $display("FAIL sa_still_fall fall_req=%b expected=1", fall_req);
    end
    game_clk = 1'b0;
    step();
    do_ack(1'b1);
    $display("test_spawn_ack done");
  endtask

  // --------------------------------------------------------------------------
  initial begin
    rst         = 1'b0;
    game_clk    = 1'b0;
    pause       = 1'b0;
    level       = 4'd0;
    soft_drop   = 1'b0;
    spawn       = 1'b0;
    fall_ack    = 1'b0;
    fall_ok     = 1'b0;
    piece_moved = 1'b0;

    test_reset();
    test_level0();
    test_fast_interval();
    test_lock();
    test_piece_moved();
    test_pause();
    test_async_reset();
    test_spawn_ack();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fall_ctrl
